// File: rtl/axis_differentiator.sv
// First-difference filter on an AXI4-Stream sample stream: y[n] = x[n] - x[n-1].
// One registered output stage with full backpressure; the first sample after
// reset only primes the history and produces no output.
module axis_differentiator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int SATURATE         = 1
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready
);

    localparam int W = AXIS_TDATA_WIDTH;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] prev;
    logic         primed;
    logic         accept;
    logic [W:0]   diff_wide;
    logic [W-1:0] diff_out;

    // The output slot is free when empty or being drained this cycle.
    assign S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready;
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;

    // One extra bit of headroom so the difference never overflows before clamping.
    assign diff_wide = {S_AXIS_tdata[W-1], S_AXIS_tdata} - {prev[W-1], prev};

    // Clamp to the signed range when the top two bits disagree, otherwise wrap.
    always_comb begin
        diff_out = diff_wide[W-1:0];
        if ((SATURATE != 0) && (diff_wide[W] != diff_wide[W-1])) begin
            diff_out = diff_wide[W] ? MIN_NEG : MAX_POS;
        end
    end

    // History: remember every accepted sample and note that priming has happened.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            prev   <= '0;
            primed <= 1'b0;
        end else if (accept) begin
            prev   <= S_AXIS_tdata;
            primed <= 1'b1;
        end
    end

    // Output register: load a new difference for primed samples, else drain on transfer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
        end else if (accept && primed) begin
            M_AXIS_tdata  <= diff_out;
            M_AXIS_tvalid <= 1'b1;
        end else if (M_AXIS_tvalid && M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_differentiator.sv
// Directed testbench for axis_differentiator: one saturating and one wrapping
// instance share the same stimulus; expected values are hand-computed or
// produced by a small arithmetic reference for the random throughput run.
module tb_axis_differentiator;

    logic        aclk;
    logic        areset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        m_tready;

    logic        sat_s_tready;
    logic [31:0] sat_m_tdata;
    logic        sat_m_tvalid;
    logic        wrap_s_tready;
    logic [31:0] wrap_m_tdata;
    logic        wrap_m_tvalid;

    int vectors;
    int miscompares;

    axis_differentiator #(.AXIS_TDATA_WIDTH(32), .SATURATE(1)) dut_sat (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (sat_s_tready),
        .M_AXIS_tdata  (sat_m_tdata),
        .M_AXIS_tvalid (sat_m_tvalid),
        .M_AXIS_tready (m_tready)
    );

    axis_differentiator #(.AXIS_TDATA_WIDTH(32), .SATURATE(0)) dut_wrap (
        .aclk          (aclk),
        .areset        (areset),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (wrap_s_tready),
        .M_AXIS_tdata  (wrap_m_tdata),
        .M_AXIS_tvalid (wrap_m_tvalid),
        .M_AXIS_tready (m_tready)
    );

    // Free-running 10 ns clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then let the clock edge take them.
    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic mready);
        s_tvalid = valid;
        s_tdata  = data;
        m_tready = mready;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid,
                               input logic [31:0] exp_sat, input logic [31:0] exp_wrap);
        checkValue({tag, ".sat_valid"}, {31'b0, sat_m_tvalid}, {31'b0, exp_valid});
        checkValue({tag, ".wrap_valid"}, {31'b0, wrap_m_tvalid}, {31'b0, exp_valid});
        if (exp_valid) begin
            checkValue({tag, ".sat_data"}, sat_m_tdata, exp_sat);
            checkValue({tag, ".wrap_data"}, wrap_m_tdata, exp_wrap);
        end
    endtask

    task automatic doReset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 32'h0;
        m_tready = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    function automatic logic [31:0] refSat(input logic [31:0] x, input logic [31:0] p);
        longint d;
        d = longint'($signed(x)) - longint'($signed(p));
        if (d > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (d < -64'sd2147483648) return 32'h8000_0000;
        else                           return d[31:0];
    endfunction

    function automatic logic [31:0] refWrap(input logic [31:0] x, input logic [31:0] p);
        return x - p;
    endfunction

    initial begin
        logic [31:0] model_prev;
        logic        model_primed;
        logic [31:0] x;
        int          outputs_seen;

        vectors     = 0;
        miscompares = 0;
        areset      = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = 32'h0;
        m_tready    = 1'b1;

        // Reset state.
        tick();
        checkValue("reset.sat_valid", {31'b0, sat_m_tvalid}, 32'd0);
        checkValue("reset.sat_data", sat_m_tdata, 32'd0);
        checkValue("reset.sat_ready", {31'b0, sat_s_tready}, 32'd1);
        checkValue("reset.wrap_ready", {31'b0, wrap_s_tready}, 32'd1);
        tick();
        areset = 1'b0;

        // Ramp: 10, 13, 20, 20, 5 -> 3, 7, 0, -15.
        applyStimulus(1'b1, 32'd10, 1'b1);
        checkOutput("ramp.prime", 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd13, 1'b1);
        checkOutput("ramp.d1", 1'b1, 32'd3, 32'd3);
        applyStimulus(1'b1, 32'd20, 1'b1);
        checkOutput("ramp.d2", 1'b1, 32'd7, 32'd7);
        applyStimulus(1'b1, 32'd20, 1'b1);
        checkOutput("ramp.d3", 1'b1, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd5, 1'b1);
        checkOutput("ramp.d4", 1'b1, 32'hFFFF_FFF1, 32'hFFFF_FFF1);
        applyStimulus(1'b0, 32'd77, 1'b1);
        checkOutput("ramp.drain", 1'b0, 32'd0, 32'd0);

        // Gapped input: 100, 90, 95 with idle cycles carrying junk data.
        doReset();
        applyStimulus(1'b1, 32'd100, 1'b1);
        checkOutput("gap.prime", 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 32'd999, 1'b1);
        applyStimulus(1'b0, 32'd999, 1'b1);
        checkOutput("gap.idle1", 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd90, 1'b1);
        checkOutput("gap.d1", 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFF6);
        applyStimulus(1'b0, 32'd12345, 1'b1);
        checkOutput("gap.idle2", 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 32'd12345, 1'b1);
        applyStimulus(1'b1, 32'd95, 1'b1);
        checkOutput("gap.d2", 1'b1, 32'd5, 32'd5);

        // Large negative step: clamps to min or wraps to +32.
        doReset();
        applyStimulus(1'b1, 32'h7FFF_FFF0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0010, 1'b1);
        checkOutput("sat.neg", 1'b1, 32'h8000_0000, 32'h0000_0020);

        // Large positive step: clamps to max or wraps to -32.
        doReset();
        applyStimulus(1'b1, 32'h8000_0010, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFF0, 1'b1);
        checkOutput("sat.pos", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFE0);

        // Edge of range: max - 0 fits exactly, max - (-1) overflows by one.
        doReset();
        applyStimulus(1'b1, 32'h0000_0000, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1);
        checkOutput("sat.exact", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        doReset();
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1);
        checkOutput("sat.over1", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000);

        // Backpressure: hold output 3 for five stalled cycles, then release.
        doReset();
        applyStimulus(1'b1, 32'd1, 1'b1);
        applyStimulus(1'b1, 32'd4, 1'b1);
        checkOutput("bp.first", 1'b1, 32'd3, 32'd3);
        s_tvalid = 1'b1;
        s_tdata  = 32'd10;
        m_tready = 1'b0;
        #1;
        checkValue("bp.ready_low", {31'b0, sat_s_tready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp.stall", 1'b1, 32'd3, 32'd3);
            checkValue("bp.stall_ready", {31'b0, sat_s_tready}, 32'd0);
        end
        m_tready = 1'b1;
        #1;
        checkValue("bp.ready_high", {31'b0, sat_s_tready}, 32'd1);
        tick();
        checkOutput("bp.second", 1'b1, 32'd6, 32'd6);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("bp.drain", 1'b0, 32'd0, 32'd0);

        // Reset mid-stream: pending 10 is discarded, 70 re-primes, only 5 emerges.
        doReset();
        applyStimulus(1'b1, 32'd50, 1'b1);
        applyStimulus(1'b1, 32'd60, 1'b1);
        checkOutput("rst.pending", 1'b1, 32'd10, 32'd10);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        checkOutput("rst.async", 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        areset = 1'b0;
        applyStimulus(1'b1, 32'd70, 1'b1);
        checkOutput("rst.reprime", 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd75, 1'b1);
        checkOutput("rst.d1", 1'b1, 32'd5, 32'd5);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("rst.drain", 1'b0, 32'd0, 32'd0);

        // Full throughput: 1000 random samples back to back.
        doReset();
        model_prev   = 32'h0;
        model_primed = 1'b0;
        outputs_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom();
            applyStimulus(1'b1, x, 1'b1);
            checkOutput("thru", model_primed, refSat(x, model_prev), refWrap(x, model_prev));
            if (sat_m_tvalid) outputs_seen++;
            model_prev   = x;
            model_primed = 1'b1;
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("thru.drain", 1'b0, 32'd0, 32'd0);
        checkValue("thru.count", outputs_seen, 32'd999);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
